// File: rtl/afe_seq_pkg.sv
// Shared types and default constants for the AFE power-up / reset sequencer.
package afe_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_ASSERT = 2'd0,
    SEQ_WAIT   = 2'd1,
    SEQ_DONE   = 2'd2
  } afe_seq_state_t;

  localparam int AFE_RESET_HOLD_CYC = 15;
  localparam int AFE_RESET_WAIT_CYC = 65520;

  localparam int                     SEQ_COUNT_W   = 8;
  localparam logic [SEQ_COUNT_W-1:0] SEQ_COUNT_MAX = {SEQ_COUNT_W{1'b1}};

endpackage

// File: rtl/afe_reset_sequencer.sv
// Pulses per-device AFE reset pins, waits a settling time, then flags done.
// One shared down-counter times both the reset pulse and the settling window.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   SEQ_ASSERT | masked device pins held active, counting the pulse width
//   SEQ_WAIT   | all pins released, counting the settling time
//   SEQ_DONE   | sequence complete, done high, counter parked at zero
module afe_reset_sequencer
  import afe_seq_pkg::*;
#(
  parameter int                 NUM_DEV       = 2,
  parameter int                 ASSERT_CYCLES = AFE_RESET_HOLD_CYC,
  parameter int                 WAIT_CYCLES   = AFE_RESET_WAIT_CYC,
  parameter int                 CNT_W         = 16,
  parameter logic [NUM_DEV-1:0] RESET_POL     = {NUM_DEV{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic [NUM_DEV-1:0]     dev_mask,
  output logic [NUM_DEV-1:0]     device_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   done_pulse,
  output logic [SEQ_COUNT_W-1:0] seq_count
);

  if (NUM_DEV < 1) begin : g_bad_num_dev
    $error("afe_reset_sequencer: NUM_DEV must be at least 1");
  end
  if (ASSERT_CYCLES < 1) begin : g_bad_assert_cycles
    $error("afe_reset_sequencer: ASSERT_CYCLES must be at least 1");
  end
  if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
    $error("afe_reset_sequencer: WAIT_CYCLES must be at least 1");
  end
  if ((64'd1 << CNT_W) < 64'(ASSERT_CYCLES) || (64'd1 << CNT_W) < 64'(WAIT_CYCLES))
  begin : g_bad_cnt_w
    $error("afe_reset_sequencer: CNT_W too narrow for ASSERT_CYCLES/WAIT_CYCLES");
  end

  localparam logic [CNT_W-1:0] LP_ASSERT_LOAD = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_WAIT_LOAD   = CNT_W'(WAIT_CYCLES - 1);

  afe_seq_state_t         r_state;
  afe_seq_state_t         w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [NUM_DEV-1:0]     r_act_mask;
  logic [NUM_DEV-1:0]     w_act_mask_nxt;
  logic                   w_cnt_zero;
  logic                   w_seq_complete;

  logic [NUM_DEV-1:0]     r_device_reset;
  logic [NUM_DEV-1:0]     w_device_reset_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   r_done_pulse;
  logic                   w_done_pulse_nxt;
  logic [SEQ_COUNT_W-1:0] r_seq_count;
  logic [SEQ_COUNT_W-1:0] w_seq_count_nxt;

  assign w_cnt_zero = (r_cnt == '0);

  // Outputs are registered copies of next-cycle values, so reset must load them too.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= SEQ_ASSERT;
      r_cnt          <= LP_ASSERT_LOAD;
      r_act_mask     <= '1;
      r_device_reset <= RESET_POL;
      r_busy         <= 1'b1;
      r_done         <= 1'b0;
      r_done_pulse   <= 1'b0;
      r_seq_count    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_act_mask     <= w_act_mask_nxt;
      r_device_reset <= w_device_reset_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_done_pulse   <= w_done_pulse_nxt;
      r_seq_count    <= w_seq_count_nxt;
    end
  end

  // restart overrides every state, including the cycle WAIT would expire.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_act_mask_nxt = r_act_mask;
    w_seq_complete = 1'b0;
    if (restart) begin
      w_state_nxt    = SEQ_ASSERT;
      w_cnt_nxt      = LP_ASSERT_LOAD;
      w_act_mask_nxt = dev_mask;
    end else begin
      case (r_state)
        SEQ_ASSERT: begin
          if (w_cnt_zero) begin
            w_state_nxt = SEQ_WAIT;
            w_cnt_nxt   = LP_WAIT_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        SEQ_WAIT: begin
          if (w_cnt_zero) begin
            w_state_nxt    = SEQ_DONE;
            w_seq_complete = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        SEQ_DONE: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = SEQ_ASSERT;
          w_cnt_nxt   = LP_ASSERT_LOAD;
        end
      endcase
    end
  end

  always_comb begin
    w_busy_nxt         = (w_state_nxt == SEQ_ASSERT) || (w_state_nxt == SEQ_WAIT);
    w_done_nxt         = (w_state_nxt == SEQ_DONE);
    w_done_pulse_nxt   = w_seq_complete;
    w_seq_count_nxt    = r_seq_count;
    if (w_seq_complete && (r_seq_count != SEQ_COUNT_MAX)) begin
      w_seq_count_nxt = r_seq_count + SEQ_COUNT_W'(1);
    end
    // Active pin bits equal RESET_POL; inactive bits are its complement.
    w_device_reset_nxt = ~(({NUM_DEV{w_state_nxt == SEQ_ASSERT}} & w_act_mask_nxt) ^ RESET_POL);
  end

  assign device_reset = r_device_reset;
  assign busy         = r_busy;
  assign done         = r_done;
  assign done_pulse   = r_done_pulse;
  assign seq_count    = r_seq_count;

endmodule

// File: tb/tb_afe_reset_sequencer.sv
// Self-checking bench for afe_reset_sequencer against an age-based reference model.
module tb_afe_reset_sequencer;

  localparam int          NUM_DEV = 2;
  localparam int          A_CYC   = 4;
  localparam int          W_CYC   = 10;
  localparam int          SEQ_LEN = A_CYC + W_CYC;
  localparam logic [1:0]  POL     = 2'b01;

  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic [1:0] dev_mask;
  logic [1:0] device_reset;
  logic       busy;
  logic       done;
  logic       done_pulse;
  logic [7:0] seq_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_seen = 0;

  // Model: edges since the last reset/restart load, plus mask and completion count.
  int         m_age;
  logic [1:0] m_mask;
  int         m_count;
  logic       m_pulse;

  always #5 clk = ~clk;

  afe_reset_sequencer #(
    .NUM_DEV      (NUM_DEV),
    .ASSERT_CYCLES(A_CYC),
    .WAIT_CYCLES  (W_CYC),
    .CNT_W        (16),
    .RESET_POL    (POL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .dev_mask    (dev_mask),
    .device_reset(device_reset),
    .busy        (busy),
    .done        (done),
    .done_pulse  (done_pulse),
    .seq_count   (seq_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_pulse = 1'b0;
    if (reset) begin
      m_age   = 0;
      m_mask  = 2'b11;
      m_count = 0;
    end else if (restart) begin
      m_age  = 0;
      m_mask = dev_mask;
    end else if (m_age < SEQ_LEN) begin
      m_age++;
      if (m_age == SEQ_LEN) begin
        m_pulse = 1'b1;
        if (m_count < 255) m_count++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [1:0] exp_dev;
    for (int i = 0; i < NUM_DEV; i++)
      exp_dev[i] = (m_age < A_CYC && m_mask[i]) ? POL[i] : ~POL[i];
    check_eq({tag, ".dev"},   32'(device_reset), 32'(exp_dev));
    check_eq({tag, ".busy"},  32'(busy),         32'(m_age < SEQ_LEN));
    check_eq({tag, ".done"},  32'(done),         32'(m_age >= SEQ_LEN));
    check_eq({tag, ".pulse"}, 32'(done_pulse),   32'(m_pulse));
    check_eq({tag, ".count"}, 32'(seq_count),    32'(m_count));
  endtask

  task automatic cycle(input logic rst, input logic rs, input logic [1:0] msk, input string tag);
    reset    = rst;
    restart  = rs;
    dev_mask = msk;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
    if (done_pulse === 1'b1) pulses_seen++;
  endtask

  function automatic logic [1:0] rnd_mask();
    return 2'($urandom_range(0, 3));
  endfunction

  initial begin
    reset    = 1'b1;
    restart  = 1'b0;
    dev_mask = 2'b00;
    m_age    = 0;
    m_mask   = 2'b11;
    m_count  = 0;
    m_pulse  = 1'b0;

    // Power-on
    repeat (3) cycle(1'b1, 1'b0, rnd_mask(), "por_rst");
    check_eq("por_pins_in_reset", 32'(device_reset), 32'(2'b01));
    repeat (SEQ_LEN + 2) cycle(1'b0, 1'b0, rnd_mask(), "por_run");
    check_eq("por_count", 32'(seq_count), 32'd1);

    // Masked restart; mask is ignored when restart is low
    cycle(1'b0, 1'b1, 2'b10, "mask_rs");
    check_eq("mask_done_falls", 32'(done), 32'd0);
    check_eq("mask_pins", 32'(device_reset), 32'(2'b00));
    repeat (SEQ_LEN + 1) cycle(1'b0, 1'b0, rnd_mask(), "mask_run");
    check_eq("mask_count", 32'(seq_count), 32'd2);

    // Abort at WAIT edge 6
    cycle(1'b0, 1'b1, 2'b11, "abort_rs");
    repeat (A_CYC + 5) cycle(1'b0, 1'b0, rnd_mask(), "abort_pre");
    cycle(1'b0, 1'b1, 2'b01, "abort_hit");
    repeat (SEQ_LEN + 1) cycle(1'b0, 1'b0, rnd_mask(), "abort_run");

    // Collision: restart on the expiry edge
    cycle(1'b0, 1'b1, 2'b11, "coll_rs");
    repeat (SEQ_LEN - 1) cycle(1'b0, 1'b0, rnd_mask(), "coll_pre");
    cycle(1'b0, 1'b1, 2'b10, "coll_hit");
    check_eq("coll_done_low", 32'(done), 32'd0);
    check_eq("coll_count", 32'(seq_count), 32'd3);
    repeat (SEQ_LEN + 1) cycle(1'b0, 1'b0, rnd_mask(), "coll_run");

    // Priority: reset beats restart, mask forced to all ones
    cycle(1'b1, 1'b1, 2'b00, "prio_both");
    check_eq("prio_pins", 32'(device_reset), 32'(2'b01));
    repeat (3) cycle(1'b0, 1'b0, rnd_mask(), "prio_run");
    cycle(1'b0, 1'b1, 2'b00, "prio_rs");
    cycle(1'b0, 1'b0, rnd_mask(), "prio_a1");
    cycle(1'b1, 1'b0, rnd_mask(), "prio_rst_mid");
    check_eq("prio_rst_busy", 32'(busy), 32'd1);
    check_eq("prio_rst_count", 32'(seq_count), 32'd0);
    repeat (SEQ_LEN + 1) cycle(1'b0, 1'b0, rnd_mask(), "prio_run2");

    // Saturation
    pulses_seen = 0;
    for (int s = 0; s < 260; s++) begin
      cycle(1'b0, 1'b1, rnd_mask(), "sat_rs");
      repeat (SEQ_LEN) cycle(1'b0, 1'b0, rnd_mask(), "sat_run");
    end
    check_eq("sat_pulses", 32'(pulses_seen), 32'd260);
    check_eq("sat_count", 32'(seq_count), 32'd255);

    // Random mix
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 11) == 0),
            rnd_mask(), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
